// File: rtl/seq_shr_pkg.sv
// Shared constants and FSM state encoding for the serial right shifter.
package seq_shr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_DATAWIDTH = 8;

   // Counter width able to hold the clamped shift amount 0..w.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_shr_if.sv
// Request/result bundle for seq_shr; arith exists only when SHR_ARITH_EN is defined.
interface seq_shr_if #(
   parameter int unsigned DATAWIDTH = 8
) ();
   logic                 start;
   logic [DATAWIDTH-1:0] a;
   logic [DATAWIDTH-1:0] sh_amt;
`ifdef SHR_ARITH_EN
   logic                 arith;
`endif
   logic                 busy;
   logic                 done;
   logic [DATAWIDTH-1:0] d;

   modport master (
`ifdef SHR_ARITH_EN
      output arith,
`endif
      output start, a, sh_amt,
      input  busy, done, d
   );

   modport slave (
`ifdef SHR_ARITH_EN
      input  arith,
`endif
      input  start, a, sh_amt,
      output busy, done, d
   );
endinterface

// File: rtl/seq_shr.sv
// Bit-serial right shifter: one bit per cycle, amount clamped to DATAWIDTH.
// Optional arithmetic mode enabled by defining SHR_ARITH_EN.
module seq_shr
   import seq_shr_pkg::*;
#(
   parameter int unsigned DATAWIDTH = DEFAULT_DATAWIDTH
) (
   input logic     Clk,
   input logic     Rst,
   seq_shr_if.slave bus
);

   localparam int unsigned CW = cnt_width(DATAWIDTH);
   localparam logic [DATAWIDTH-1:0] DW_V  = DATAWIDTH'(DATAWIDTH);
   localparam logic [CW-1:0]        DW_C  = CW'(DATAWIDTH);

   state_t               state_q, state_d;
   logic [DATAWIDTH-1:0] work_q;
   logic [CW-1:0]        count_q;
   logic [DATAWIDTH-1:0] d_q;
   logic                 busy_c, done_c;
   logic                 fill;

`ifdef SHR_ARITH_EN
   logic arith_q;

   // Work MSB never changes in arithmetic mode, so it still holds the operand sign.
   assign fill = arith_q & work_q[DATAWIDTH-1];

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         arith_q <= 1'b0;
      else if (state_q == IDLE && bus.start)
         arith_q <= bus.arith;
   end
`else
   assign fill = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start)
               state_d = SHIFT;
         end
         SHIFT: begin
            busy_c = 1'b1;
            if (count_q == '0)
               state_d = DONE;
         end
         DONE: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         work_q  <= '0;
         count_q <= '0;
         d_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  work_q  <= bus.a;
                  count_q <= (bus.sh_amt >= DW_V) ? DW_C : CW'(bus.sh_amt);
               end
            end
            SHIFT: begin
               if (count_q != '0) begin
                  work_q  <= {fill, work_q[DATAWIDTH-1:1]};
                  count_q <= count_q - CW'(1);
               end else begin
                  d_q <= work_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.d    = d_q;

endmodule

// File: doc/seq_shr.md
SEQ_SHR -- requirements
Module: seq_shr

Interface
REQ-001 Parameter DATAWIDTH, default 8, SHALL set the operand, shift-amount and result width in bits.
REQ-002 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 start  input  1  SHALL request one shift operation when high in IDLE.
REQ-005 a  input  DATAWIDTH  SHALL be the operand, sampled only on the accepting edge.
REQ-006 sh_amt  input  DATAWIDTH  SHALL be the unsigned right-shift amount, sampled with a.
REQ-007 arith  input  1  SHALL select arithmetic (1) or logical (0) shift; present only when SHR_ARITH_EN is defined.
REQ-008 busy  output  1  SHALL be high while an accepted operation is in progress (SHIFT state).
REQ-009 done  output  1  SHALL pulse high for exactly one cycle when d holds a new result.
REQ-010 d  output  DATAWIDTH  SHALL be the registered result, i.e. a >> sh_amt.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-012 IDLE: start high on a rising edge SHALL load work register = a and count = min(sh_amt, DATAWIDTH), then go to SHIFT.
REQ-013 SHIFT: each rising edge with count != 0 SHALL shift the work register right by one bit and decrement count.
REQ-014 SHIFT: a rising edge with count == 0 SHALL copy the work register to d and go to DONE.
REQ-015 DONE SHALL last exactly one cycle with done = 1, then return to IDLE unconditionally.
REQ-016 Latency: done SHALL be high in the cycle after the (L+1)-th rising edge following the accepting edge, where L = min(sh_amt, DATAWIDTH).
REQ-017 sh_amt >= DATAWIDTH SHALL clamp to DATAWIDTH, giving result 0 (logical), or all bits equal to a[MSB] (arithmetic).
REQ-018 sh_amt = 0 SHALL return d = a with done one cycle after SHIFT entry.
REQ-019 start while in SHIFT or DONE SHALL be ignored; it SHALL NOT corrupt the operation in flight or queue a request.
REQ-020 Changes on a or sh_amt after acceptance SHALL NOT affect the result.
REQ-021 d SHALL hold its last value in IDLE, SHIFT and DONE until the next REQ-014 update.
REQ-022 busy SHALL be 1 only in SHIFT; done SHALL be 1 only in DONE.

Reset
REQ-023 Rst low SHALL immediately force state = IDLE, busy = 0, done = 0, d = 0, count = 0 and work register = 0, independent of Clk.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-025 After Rst deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-026 Macro SHR_ARITH_EN defined: the arith port SHALL exist and be sampled with a; when it is 1, each shift step SHALL replicate the operand MSB into the vacated bit.
REQ-027 SHR_ARITH_EN undefined: the arith port SHALL be absent and every shift SHALL be logical (zero fill).

Structure
REQ-028 The state encoding (IDLE/SHIFT/DONE typedef) SHALL live in the shared datapath package with the other component constants.
REQ-029 No sub-module is required; an optional single-bit shift step may be factored as shr_step.

Verification (DATAWIDTH=8)
REQ-030 a=8'hB4, sh_amt=3, start for 1 cycle -> busy for 4 cycles, done pulse, d=8'h16.
REQ-031 a=8'hB4, sh_amt=0 -> d=8'hB4, done one cycle after busy rises; sh_amt=9 -> d=8'h00 after 8 shifts (clamped).
REQ-032 SHR_ARITH_EN defined: a=8'hB4, sh_amt=3, arith=1 -> d=8'hF6; arith=0 -> d=8'h16; sh_amt=200, arith=1 -> d=8'hFF.
REQ-033 a=8'hF0, sh_amt=4 accepted; then start held high with a=8'h0F, sh_amt=1 during SHIFT -> single done, d=8'h0F; next start in IDLE accepted.
REQ-034 Rst pulled low 2 cycles into a sh_amt=6 operation -> outputs 0 immediately, no done; after release a=8'h80, sh_amt=7 -> d=8'h01.
